// File: rtl/rr_arbiter_16.sv
// -----------------------------------------------------------------------------
// rr_arbiter_16
//
// Purpose:
//   16-requester round-robin arbiter feeding a 4-to-16 decoder. The arbiter
//   registers a grant index (decoder select) and a valid strobe (decoder
//   enable). A grant is held until its owner pulses done or drops its request.
//   The next search starts just past the most recently released owner, so
//   every requester eventually gets served.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high reset
//   req          in  16   level-sensitive request lines, bit i = requester i
//   done         in   1   single-cycle release pulse from the current owner
//   grant_index  out  4   index of the granted requester (held while invalid)
//   grant_valid  out  1   high while a grant is active
//   last_index   out  4   index of the most recently released grant
//   timeout      out  1   one-cycle pulse on a forced release (0 when disabled)
//
// Configuration:
//   ARB_TIMEOUT_EN  When defined, the parameter TIMEOUT (1..255, default 15)
//                   bounds each grant to TIMEOUT cycles. An 8-bit hold counter
//                   force-releases the owner and pulses timeout. When it is
//                   undefined, there is no TIMEOUT parameter, no counter is
//                   built, timeout is tied to 0 and grants are unbounded.
// -----------------------------------------------------------------------------
module rr_arbiter_16
`ifdef ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = 15
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  grant_index,
    output logic        grant_valid,
    output logic [3:0]  last_index,
    output logic        timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q;
    logic [3:0]  grant_index_q;
    logic        grant_valid_q;
    logic [3:0]  last_index_q;

    logic [15:0] rot_req;
    logic [3:0]  rot_off;
    logic [3:0]  pick_idx;
    logic        release_normal;
    logic        expire;

    // The request vector is rotated so that bit 0 is the requester just past
    // last_index. The lowest set bit of rot_req is then the round-robin winner.
    // The 4-bit add wraps modulo 16, so the last owner is checked last.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rot
            assign rot_req[gi] = req[last_index_q + 4'(gi + 1)];
        end
    endgenerate

    always_comb begin
        rot_off = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (rot_req[k]) begin
                rot_off = 4'(k);
            end
        end
    end

    assign pick_idx = last_index_q + rot_off + 4'd1;

    // done and a request drop in the same cycle are one release, not two.
    assign release_normal = done | ~req[grant_index_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] hold_cnt_q;
    logic       timeout_q;

    assign expire = (hold_cnt_q == HOLD_LAST);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_index_q <= 4'd0;
            grant_valid_q <= 1'b0;
            last_index_q  <= 4'd15;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q    <= 8'd0;
            timeout_q     <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_index_q <= pick_idx;
                        grant_valid_q <= 1'b1;
                        state_q       <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_q    <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (release_normal || expire) begin
                        grant_valid_q <= 1'b0;
                        last_index_q  <= grant_index_q;
                        state_q       <= IDLE;
`ifdef ARB_TIMEOUT_EN
                        // A normal release on the expiry cycle wins, so the
                        // pulse only marks a genuinely forced release.
                        timeout_q     <= ~release_normal;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_q       <= IDLE;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_index = grant_index_q;
    assign grant_valid = grant_valid_q;
    assign last_index  = last_index_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_16
//
// Self-checking bench for rr_arbiter_16. It runs a directed sequence that
// follows the arbiter's documented scenarios and then a randomized phase. Each
// cycle the bench compares the DUT outputs with a behavioural model. The model
// tracks only whether a grant is held, who owns it, who released last and how
// long the grant has lasted. It picks the next owner by scanning requesters
// (last+1), (last+2), ... modulo 16.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_arbiter_16;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_EN = 1;
    localparam int TMO   = 4;
`else
    localparam int TO_EN = 0;
    localparam int TMO   = 15;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic [3:0]  grant_index;
    logic        grant_valid;
    logic [3:0]  last_index;
    logic        timeout;

    int n_cmp;
    int n_err;

    // behavioural model state
    logic        m_valid;
    logic [3:0]  m_idx;
    logic [3:0]  m_last;
    logic        m_to;
    int          m_held;

`ifdef ARB_TIMEOUT_EN
    rr_arbiter_16 #(.TIMEOUT(TMO)) dut (
`else
    rr_arbiter_16 dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant_index (grant_index),
        .grant_valid (grant_valid),
        .last_index  (last_index),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First requester found when scanning upward from last+1 with wrap-around.
    function automatic logic [3:0] next_owner(input logic [3:0] last,
                                              input logic [15:0] r);
        int idx;
        next_owner = 4'd0;
        for (int k = 16; k >= 1; k--) begin
            idx = (int'(last) + k) % 16;
            if (r[idx]) next_owner = 4'(idx);
        end
    endfunction

    // Advance the model by one clock edge, using the inputs seen at that edge.
    task automatic model_edge(input logic [15:0] r, input logic d, input logic rst);
        logic rel;
        logic exp_to;
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 4'd0;
            m_last  = 4'd15;
            m_to    = 1'b0;
            m_held  = 0;
        end else if (!m_valid) begin
            m_to = 1'b0;
            if (r != 16'h0) begin
                m_idx   = next_owner(m_last, r);
                m_valid = 1'b1;
                m_held  = 1;
                $display("grant   idx=%0d req=%h last=%0d t=%0t", m_idx, r, m_last, $time);
            end
        end else begin
            rel    = d || !r[m_idx];
            exp_to = (TO_EN == 1) && (m_held >= TMO);
            if (rel || exp_to) begin
                m_valid = 1'b0;
                m_last  = m_idx;
                m_to    = exp_to && !rel;
                $display("release idx=%0d forced=%0d t=%0t", m_idx, m_to, $time);
            end else begin
                m_to   = 1'b0;
                m_held = m_held + 1;
            end
        end
    endtask

    // One cycle: drive on the falling edge, update the model at the rising
    // edge, and compare the DUT with the model 1 ns later.
    task automatic step(input logic [15:0] r, input logic d, input logic rst);
        @(negedge clk);
        req   = r;
        done  = d;
        reset = rst;
        @(posedge clk);
        model_edge(r, d, rst);
        #1;
        check_eq("grant_valid", grant_valid, m_valid);
        check_eq("grant_index", grant_index, m_idx);
        check_eq("last_index",  last_index,  m_last);
        check_eq("timeout",     timeout,     m_to);
    endtask

    initial begin
        logic [15:0] r;
        n_cmp  = 0;
        n_err  = 0;
        req    = 16'h0;
        done   = 1'b0;
        reset  = 1'b1;
        m_valid = 1'b0; m_idx = 4'd0; m_last = 4'd15; m_to = 1'b0; m_held = 0;

        // reset, then idle with no requests
        step(16'h0, 1'b0, 1'b1);
        step(16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(16'h0, 1'b0, 1'b0);
            check_eq("idle_valid", grant_valid, 0);
            check_eq("idle_last",  last_index, 15);
        end

        // single requester 0: 1-cycle latency, release on done
        step(16'h0001, 1'b0, 1'b0);
        check_eq("r0_valid", grant_valid, 1);
        check_eq("r0_index", grant_index, 0);
        step(16'h0001, 1'b0, 1'b0);
        step(16'h0001, 1'b0, 1'b0);
        step(16'h0001, 1'b1, 1'b0);
        check_eq("r0_release_valid", grant_valid, 0);
        check_eq("r0_release_last",  last_index, 0);
        step(16'h0, 1'b0, 1'b0);

        // all requesting: strict rotation with a dead cycle between owners
        step(16'h0, 1'b0, 1'b1);
        for (int n = 0; n < 17; n++) begin
            step(16'hFFFF, 1'b0, 1'b0);
            check_eq("rot_index", grant_index, n % 16);
            step(16'hFFFF, 1'b0, 1'b0);
            step(16'hFFFF, 1'b1, 1'b0);
            check_eq("rot_dead", grant_valid, 0);
        end

        // wrap search: last=14 and req=4001 must select 0, not 14
        step(16'h0, 1'b0, 1'b1);
        step(16'h4000, 1'b0, 1'b0);
        step(16'h4000, 1'b1, 1'b0);
        check_eq("wrap_last", last_index, 14);
        step(16'h4001, 1'b0, 1'b0);
        check_eq("wrap_index", grant_index, 0);
        step(16'h4001, 1'b1, 1'b0);

        // request drop releases without done; reset mid-grant records nothing
        step(16'h0020, 1'b0, 1'b0);
        check_eq("drop_index", grant_index, 5);
        step(16'h0020, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        check_eq("drop_valid", grant_valid, 0);
        check_eq("drop_last",  last_index, 5);
        step(16'h0100, 1'b0, 1'b0);
        check_eq("pre_rst_index", grant_index, 8);
        step(16'h0100, 1'b0, 1'b1);
        check_eq("rst_valid", grant_valid, 0);
        check_eq("rst_last",  last_index, 15);

        // held request with no done (bounded only when the timeout is built)
        step(16'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            step(16'h0008, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
            check_eq("tmo_valid", grant_valid, (i == 5) ? 0 : 1);
            check_eq("tmo_pulse", timeout, (i == 5) ? 1 : 0);
            check_eq("tmo_index", grant_index, 3);
`else
            check_eq("hold_valid", grant_valid, 1);
`endif
        end
        step(16'h0008, 1'b1, 1'b0);

        // randomized traffic
        r = 16'h0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 16'($urandom) & 16'($urandom) & 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 3) == 0) r = 16'($urandom);
            end
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- 16-requester round-robin arbiter.
- Emits a registered 4-bit grant index plus a valid/enable strobe that drive decoder_4x16 directly: grant_index feeds its select inputs and grant_valid feeds its enable. The decoder therefore produces the one-hot grant vector.
- Sits directly upstream of the decoder in the shared-resource select path.
- Holds each grant until the owner releases it. Rotates priority so no requester starves.

Parameters:
- TIMEOUT, default 15: max cycles a grant may be held. Used only when ARB_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  16  request lines; bit i = requester i; level-sensitive.
- done  input  1  single-cycle release pulse from the current owner.
- grant_index  output  4  index of the granted requester; drives decoder select.
- grant_valid  output  1  high while a grant is active; drives decoder enable.
- last_index  output  4  index of the most recently released grant (rotation pointer).
- timeout  output  1  one-cycle pulse on a forced release. Tied 0 when the feature is out.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values: grant_valid=0, grant_index=0, last_index=15, timeout=0, state=IDLE, hold counter=0.
- Reset asserted mid-grant: grant is dropped at that edge. No release is recorded; last_index returns to 15.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, search upward from (last_index+1) mod 16 with wrap-around. Pick the first i with req[i]=1.
  - On the next edge: grant_index<=i, grant_valid<=1, state<=GRANT.
  - Latency from req sampled high to grant_valid high: 1 cycle.
- Search wrap example: last_index=14 searches 15,0,1,...,14. Requester 14 itself is checked last, so it is granted again only when no other request is set.
- GRANT:
  - grant_index is frozen while in this state.
  - Release condition, evaluated each cycle: done==1 OR req[grant_index]==0. With ARB_TIMEOUT_EN, also a timeout expiry.
  - On release: next edge sets grant_valid<=0, last_index<=grant_index, state<=IDLE.
  - grant_index keeps its value while invalid.
- Dead cycle: there is always at least one cycle with grant_valid=0 between consecutive grants, so the decoder outputs go all-zero between owners.
- Changes to other req bits during GRANT are ignored until the return to IDLE.
- done asserted in IDLE is ignored.
- done and a req drop in the same cycle count as a single release.
- All 16 requests set continuously: grants cycle 0,1,2,...,15,0,..., each grant lasting until done.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches TIMEOUT-1 without another release, the arbiter force-releases on the next edge, exactly as a normal release: grant_valid<=0, last_index updated, state<=IDLE.
  - timeout is pulsed high for that one cycle, aligned with grant_valid falling.
  - Maximum grant length: TIMEOUT cycles.
  - A normal release on the same cycle as expiry takes precedence and timeout stays 0.
- Undefined: no counter is built, timeout is constant 0, and grants are unbounded.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> grant_valid=0, grant_index=0, last_index=15 throughout.
- req=16'h0001 from cycle 0 -> grant_valid=1, grant_index=0 at cycle 1. done pulse at cycle 4 -> grant_valid=0 at cycle 5, last_index=0.
- req=16'hFFFF held, done pulsed 2 cycles after each grant -> grant order 0,1,2,...,15,0. One invalid cycle between grants.
- last_index=14, req=16'h4001 -> grant_index=0 (wrap search checks 15 then 0), not 14.
- Grant active on index 5, req[5] drops with no done -> grant_valid=0 next cycle, last_index=5. Reset asserted during another grant -> grant_valid=0 and last_index=15 after the edge.
- ARB_TIMEOUT_EN, TIMEOUT=4, req=16'h0008 held with no done -> grant_valid high for exactly 4 cycles. timeout=1 in the cycle grant_valid falls, then index 3 is re-granted after the dead cycle.
